ws2818_frame_ctrl: RTL and testbench

Upstream sequencer for the nrz serializer in the ws2818 core. On a start strobe it reads NUM_LEDS pixels from a synchronous pixel RAM and reorders each from RGB to the GRB wire order. It hands each pixel to nrz through a valid/din/done handshake, then holds the line idle for the latch period. It also generates the shared clken bit-timing strobe consumed by nrz.

---
 rtl/ws2818_frame_ctrl.sv | 129 ++++++++++++
 tb/tb_ws2818_frame_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ws2818_frame_ctrl.sv
// Frame sequencer for the ws2818 nrz serializer: fetches pixels from a sync RAM,
// reorders RGB->GRB, hands them to nrz on the clken grid, then holds the latch period.
module ws2818_frame_ctrl #(
  parameter int NUM_LEDS    = 8,
  parameter int DATA_WIDTH  = 24,
  parameter int ADDR_WIDTH  = 3,
  parameter int TICK_DIV    = 25,
  parameter int LATCH_TICKS = 1200
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  pix_rd,
  output logic [ADDR_WIDTH-1:0] pix_addr,
  input  logic [DATA_WIDTH-1:0] pix_data,
  output logic                  clken,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] din,
  input  logic                  done
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int LW = (LATCH_TICKS > 1) ? $clog2(LATCH_TICKS) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, LOAD, SEND, LATCH} state_t;

  state_t                  state_q, state_d;
  logic [DW-1:0]           div_q, div_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [LW-1:0]           lcnt_q, lcnt_d;
  logic                    busy_q, busy_d;
  logic                    fd_q, fd_d;
  logic                    valid_q, valid_d;
  logic [DATA_WIDTH-1:0]   din_q, din_d;

  always_comb begin
    clken = (div_q == DW'(TICK_DIV - 1));
    div_d = clken ? '0 : div_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lcnt_d  = lcnt_q;
    busy_d  = busy_q;
    fd_d    = 1'b0;
    valid_d = valid_q;
    din_d   = din_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          busy_d  = 1'b1;
          idx_d   = '0;
        end
      end
      FETCH:   state_d = CAPTURE;
      CAPTURE: begin
        din_d   = {pix_data[15:8], pix_data[23:16], pix_data[7:0]};
        valid_d = 1'b1;
        state_d = LOAD;
      end
      LOAD: begin
        if (clken) begin
          valid_d = 1'b0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (clken && done) begin
          if (idx_q == ADDR_WIDTH'(NUM_LEDS - 1)) begin
            state_d = LATCH;
            lcnt_d  = '0;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      LATCH: begin
        // Stay in LATCH for the frame_done cycle so a coincident start is dropped.
        if (fd_q) begin
          state_d = IDLE;
        end else if (clken) begin
          if (lcnt_q == LW'(LATCH_TICKS - 1)) begin
            fd_d   = 1'b1;
            busy_d = 1'b0;
          end else begin
            lcnt_d = lcnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      idx_q   <= '0;
      lcnt_q  <= '0;
      busy_q  <= 1'b0;
      fd_q    <= 1'b0;
      valid_q <= 1'b0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      lcnt_q  <= lcnt_d;
      busy_q  <= busy_d;
      fd_q    <= fd_d;
      valid_q <= valid_d;
      din_q   <= din_d;
    end
  end

  // idx only moves on entry to FETCH, so it doubles as the held read address.
  assign pix_rd     = (state_q == FETCH);
  assign pix_addr   = idx_q;
  assign busy       = busy_q;
  assign frame_done = fd_q;
  assign valid      = valid_q;
  assign din        = din_q;

endmodule

// File: tb/tb_ws2818_frame_ctrl.sv
// Scoreboard bench for ws2818_frame_ctrl with a sync RAM model and an nrz done model.
module tb_ws2818_frame_ctrl;

  localparam int NUM_LEDS    = 4;
  localparam int ADDR_WIDTH  = 3;
  localparam int TICK_DIV    = 25;
  localparam int LATCH_TICKS = 20;
  localparam int DONE_AFTER  = 24;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, frame_done, pix_rd, clken, valid;
  logic [2:0]  pix_addr;
  logic [23:0] pix_data = '0;
  logic [23:0] din;
  logic        done = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  logic [23:0] ram [8];
  logic [23:0] exp_din [$];
  logic [2:0]  exp_addr [$];

  ws2818_frame_ctrl #(
    .NUM_LEDS(NUM_LEDS), .DATA_WIDTH(24), .ADDR_WIDTH(ADDR_WIDTH),
    .TICK_DIV(TICK_DIV), .LATCH_TICKS(LATCH_TICKS)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .frame_done(frame_done),
    .pix_rd(pix_rd), .pix_addr(pix_addr), .pix_data(pix_data), .clken(clken),
    .valid(valid), .din(din), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (pix_rd) pix_data <= ram[pix_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // nrz model + output monitor; done changes mid-cycle and is sampled on the next posedge
  int   m_nv, m_nd, m_nf, m_cnt, m_since, m_lcnt;
  logic m_active, m_in_latch, p_clk, p_valid, p_done, p_fd;

  always @(negedge clk) begin
    if (reset) begin
      done = 0; m_active = 0; m_cnt = 0; m_nv = 0; m_nd = 0; m_nf = 0;
      m_since = 0; m_lcnt = 0; m_in_latch = 0;
      p_clk = 0; p_valid = 0; p_done = 0; p_fd = 0;
    end else begin
      if (p_clk) begin
        if (p_valid) begin
          m_active = 1; m_cnt = 0;
        end else if (p_done) begin
          done = 0; m_active = 0; m_since = 0; m_nd++;
          if (m_nd == NUM_LEDS) begin m_in_latch = 1; m_lcnt = 0; end
        end else if (m_active) begin
          m_cnt++;
        end
        if (m_active && m_cnt == DONE_AFTER - 1) done = 1;
      end
      if (pix_rd) begin
        if (m_nf > 0) chk("fetch_timing", {31'd0, p_clk & p_done}, 1);
        if (exp_addr.size() == 0) chk("extra_fetch", 1, 0);
        else chk("pix_addr", {29'd0, pix_addr}, {29'd0, exp_addr.pop_front()});
        m_nf++;
      end
      if (p_clk && p_valid) chk("valid_drop", {31'd0, valid}, 0);
      if (clken && valid) begin
        if (m_nv > 0) chk("gap_clkens", m_since, 0);
        if (exp_din.size() == 0) chk("extra_valid", 1, 0);
        else chk("din", {8'd0, din}, {8'd0, exp_din.pop_front()});
        m_nv++;
      end
      if (clken) m_since++;
      if (m_in_latch && clken) m_lcnt++;
      if (p_fd) chk("fd_pulse", {31'd0, frame_done}, 0);
      if (frame_done) begin
        chk("latch_clkens", m_lcnt, LATCH_TICKS);
        chk("busy_at_fd", {31'd0, busy}, 0);
        chk("pixels_sent", m_nv, NUM_LEDS);
        m_nv = 0; m_nd = 0; m_nf = 0; m_in_latch = 0;
      end
      p_clk = clken; p_valid = valid; p_done = done; p_fd = frame_done;
    end
  end

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_fd();
    int k = 0;
    do begin @(negedge clk); k++; end while (!frame_done && k < 10000);
    if (!frame_done) chk("frame_done_timeout", 0, 1);
  endtask

  task automatic push_rand_frame();
    for (int i = 0; i < NUM_LEDS; i++) begin
      logic [23:0] p;
      p = 24'($urandom);
      ram[i] = p;
      exp_din.push_back({p[15:8], p[23:16], p[7:0]});
      exp_addr.push_back(3'(i));
    end
  endtask

  logic [23:0] t_ram [4] = '{24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C};
  logic [23:0] t_exp [4] = '{24'h020103, 24'h050406, 24'h080709, 24'h0B0A0C};

  initial begin
    int n, k;
    logic any;
    for (int i = 0; i < 8; i++) ram[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_valid", {31'd0, valid}, 0);
    chk("rst_pix_rd", {31'd0, pix_rd}, 0);
    chk("rst_clken", {31'd0, clken}, 0);
    chk("rst_din", {8'd0, din}, 0);
    reset = 0;

    // the release cycle counts as clk 1, so the first pulse lands on clk TICK_DIV
    n = 0;
    do begin @(negedge clk); n++; end while (!clken && n < 100);
    chk("first_clken_clk", n + 1, TICK_DIV);
    n = 0;
    do begin @(negedge clk); n++; end while (!clken && n < 100);
    chk("clken_period", n, TICK_DIV);
    any = 0;
    repeat (60) begin @(negedge clk); any = any | busy | valid | pix_rd; end
    chk("idle_quiet", {31'd0, any}, 0);

    // frame 1: fixed table; start pulses in SEND and LATCH must be ignored
    for (int i = 0; i < NUM_LEDS; i++) begin
      ram[i] = t_ram[i];
      exp_din.push_back(t_exp[i]);
      exp_addr.push_back(3'(i));
    end
    pulse_start();
    chk("busy_after_start", {31'd0, busy}, 1);
    repeat (200) @(negedge clk);
    pulse_start();
    chk("busy_in_send", {31'd0, busy}, 1);
    k = 0;
    while (!m_in_latch && k < 5000) begin @(negedge clk); k++; end
    chk("reach_latch", {31'd0, m_in_latch}, 1);
    repeat (50) @(negedge clk);
    pulse_start();
    wait_fd();

    // start coincident with frame_done is dropped; the next clk's start is taken
    push_rand_frame();
    start = 1;
    @(negedge clk);
    chk("start_at_fd_busy", {31'd0, busy}, 0);
    @(negedge clk);
    start = 0;
    chk("start_after_fd_busy", {31'd0, busy}, 1);
    chk("start_after_fd_rd", {31'd0, pix_rd}, 1);
    chk("start_after_fd_addr", {29'd0, pix_addr}, 0);

    // frame 2 aborted by reset while pixel 2 is in SEND
    k = 0;
    while (m_nf < 3 && k < 5000) begin @(negedge clk); k++; end
    chk("reach_pixel2", m_nf, 3);
    repeat (100) @(negedge clk);
    reset = 1;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_valid", {31'd0, valid}, 0);
    chk("mid_rst_din", {8'd0, din}, 0);
    chk("mid_rst_addr", {29'd0, pix_addr}, 0);
    chk("mid_rst_clken", {31'd0, clken}, 0);
    chk("mid_rst_fd", {31'd0, frame_done}, 0);
    exp_din.delete();
    exp_addr.delete();
    repeat (3) @(negedge clk);
    reset = 0;
    repeat (5) @(negedge clk);

    // frame 3: restart from address 0
    push_rand_frame();
    pulse_start();
    chk("restart_rd", {31'd0, pix_rd}, 1);
    chk("restart_addr", {29'd0, pix_addr}, 0);
    wait_fd();
    repeat (3) @(negedge clk);
    chk("sb_din_empty", exp_din.size(), 0);
    chk("sb_addr_empty", exp_addr.size(), 0);
    chk("idle_busy", {31'd0, busy}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
